// File: rtl/asg_sweep_ctrl_pkg.sv
// asg_sweep_ctrl_pkg
//   Shared definitions for the ASG frequency-sweep sequencer: FSM state
//   encodings, sweep mode codes and the default dwell prescaler ratio.
package asg_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DWELL  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_st_e;

  // Mode code 3 is decoded as one-shot.
  localparam logic [1:0] MODE_ONCE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_PPONG  = 2'd2;

  // 1 us dwell tick at 125 MHz dac_clk.
  localparam int TICK_DIV_DEF = 125;

endpackage

// File: rtl/asg_sweep_ctrl_tick_gen.sv
// asg_tick_gen
//   Dwell prescaler: one-cycle tick every TICK_DIV clocks.
//   Ports: clk_i/rst_n_i clock and async active-low reset,
//          clr_i  synchronous phase restart (sweep start),
//          tick_o one-cycle tick.
//   TICK_DIV must be >= 2 (the UPDATE cycle is part of each dwell period).
module asg_tick_gen #(
  parameter int TICK_DIV = 125
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  // The start cycle plays the role of an UPDATE cycle, so the prescaler
  // restarts one count in; every step is then held exactly dwell*TICK_DIV.
  localparam logic [CW-1:0] PHASE = (TICK_DIV > 1) ? CW'(1) : CW'(0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr_i)              cnt_d = PHASE;
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/asg_sweep_ctrl.sv
// asg_sweep_ctrl
//   Frequency-sweep sequencer for one ASG channel. Steps the channel's
//   phase-step word from f_start to f_stop (linear or geometric increments)
//   with a programmable dwell, in one-shot, repeat or ping-pong mode.
//   Ports: dac_clk_i/dac_rstn_i clock, async active-low reset;
//          cfg_* sweep configuration (latched at start except en/stop);
//          trig_i hardware start; step_o/step_upd_o step word + change pulse;
//          busy_o sweeping; done_o one-shot finished; pass_cnt_o passes.
module asg_sweep_ctrl
  import asg_sweep_ctrl_pkg::*;
#(
  parameter int RSZ      = 14,
  parameter int STEP_W   = RSZ + 48,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic              dac_clk_i,
  input  logic              dac_rstn_i,
  input  logic              cfg_en_i,
  input  logic              cfg_start_i,
  input  logic              cfg_stop_i,
  input  logic              trig_i,
  input  logic              cfg_trig_en_i,
  input  logic [STEP_W-1:0] cfg_f_start_i,
  input  logic [STEP_W-1:0] cfg_f_stop_i,
  input  logic [STEP_W-1:0] cfg_delta_i,
  input  logic              cfg_log_i,
  input  logic [5:0]        cfg_shift_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [31:0]       cfg_dwell_i,
  output logic [STEP_W-1:0] step_o,
  output logic              step_upd_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       pass_cnt_o
);

  sweep_st_e         state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d, org_q, org_d, tgt_q, tgt_d, delta_q, delta_d;
  logic              dir_up_q, dir_up_d, log_q, log_d, upd_q, upd_d, done_q, done_d;
  logic [5:0]        shift_q, shift_d;
  logic [1:0]        mode_q, mode_d;
  logic [31:0]       dwell_q, dwell_d, dcnt_q, dcnt_d;
  logic [15:0]       pass_q, pass_d;

  logic              abort, start, tick, upd_req, reached;
  logic [STEP_W-1:0] shr, inc;
  logic [STEP_W:0]   nxt;

  // Stop (or enable low) wins over a coincident start.
  assign abort = cfg_stop_i | ~cfg_en_i;
  assign start = (cfg_start_i | (trig_i & cfg_trig_en_i)) & ~abort;

  asg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i   (dac_clk_i),
    .rst_n_i (dac_rstn_i),
    .clr_i   (start),
    .tick_o  (tick)
  );

  // Next step candidate, one extra bit to catch carry/borrow past the rails.
  always_comb begin
    shr = step_q >> shift_q;
    if (!log_q)         inc = delta_q;
    else if (shr == '0) inc = STEP_W'(1);
    else                inc = shr;
    if (dir_up_q) begin
      nxt     = {1'b0, step_q} + {1'b0, inc};
      reached = nxt[STEP_W] | (nxt[STEP_W-1:0] >= tgt_q);
    end else begin
      nxt     = {1'b0, step_q} - {1'b0, inc};
      reached = nxt[STEP_W] | (nxt[STEP_W-1:0] <= tgt_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    org_d    = org_q;
    tgt_d    = tgt_q;
    delta_d  = delta_q;
    dir_up_d = dir_up_q;
    log_d    = log_q;
    shift_d  = shift_q;
    mode_d   = mode_q;
    dwell_d  = dwell_q;
    dcnt_d   = dcnt_q;
    pass_d   = pass_q;
    done_d   = done_q;
    upd_req  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      step_d  = cfg_f_start_i;
      done_d  = 1'b0;
    end else if (start) begin
      state_d  = ST_DWELL;
      step_d   = cfg_f_start_i;
      upd_req  = 1'b1;
      done_d   = 1'b0;
      pass_d   = '0;
      org_d    = cfg_f_start_i;
      tgt_d    = cfg_f_stop_i;
      dir_up_d = (cfg_f_stop_i >= cfg_f_start_i);
      delta_d  = cfg_delta_i;
      log_d    = cfg_log_i;
      shift_d  = cfg_shift_i;
      mode_d   = cfg_mode_i;
      dwell_d  = (cfg_dwell_i == '0) ? 32'd1 : cfg_dwell_i;
      dcnt_d   = (cfg_dwell_i == '0) ? 32'd1 : cfg_dwell_i;
    end else begin
      case (state_q)
        ST_IDLE: step_d = cfg_f_start_i;
        ST_DWELL: begin
          if (tick) begin
            if (dcnt_q == 32'd1) state_d = ST_UPDATE;
            else                 dcnt_d  = dcnt_q - 32'd1;
          end
        end
        ST_UPDATE: begin
          state_d = ST_DWELL;
          dcnt_d  = dwell_q;
          if (!reached) begin
            step_d = nxt[STEP_W-1:0];
          end else if (step_q != tgt_q) begin
            step_d = tgt_q;                 // clamp: final dwell sits on target
          end else begin
            // Target already held for a full dwell: pass complete.
            if (pass_q != 16'hffff) pass_d = pass_q + 16'd1;
            case (mode_q)
              MODE_REPEAT: step_d = org_q;
              MODE_PPONG: begin
                org_d    = tgt_q;
                tgt_d    = org_q;
                dir_up_d = ~dir_up_q;
              end
              default: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            endcase
          end
          // Zero-delta holds and ping-pong turnarounds do not pulse.
          upd_req = (step_d != step_q);
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    // Guarantees no back-to-back pulses (restart right after an update).
    upd_d = upd_req & ~upd_q;
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      org_q    <= '0;
      tgt_q    <= '0;
      delta_q  <= '0;
      dir_up_q <= 1'b0;
      log_q    <= 1'b0;
      shift_q  <= '0;
      mode_q   <= '0;
      dwell_q  <= '0;
      dcnt_q   <= '0;
      pass_q   <= '0;
      done_q   <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      org_q    <= org_d;
      tgt_q    <= tgt_d;
      delta_q  <= delta_d;
      dir_up_q <= dir_up_d;
      log_q    <= log_d;
      shift_q  <= shift_d;
      mode_q   <= mode_d;
      dwell_q  <= dwell_d;
      dcnt_q   <= dcnt_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      upd_q    <= upd_d;
    end
  end

  assign step_o     = step_q;
  assign step_upd_o = upd_q;
  assign busy_o     = (state_q == ST_DWELL) || (state_q == ST_UPDATE);
  assign done_o     = done_q;
  assign pass_cnt_o = pass_q;

endmodule

// File: tb/tb_asg_sweep_ctrl.sv
// tb_asg_sweep_ctrl
//   Directed bench for asg_sweep_ctrl with TICK_DIV=4: linear, clamped,
//   down, geometric, ping-pong, repeat and zero-delta sweeps, abort/trigger
//   handling and asynchronous reset.
module tb_asg_sweep_ctrl;

  localparam int STEP_W = 62;
  localparam int BUDGET = 300;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              en = 1'b1, start = 1'b0, stop = 1'b0, trig = 1'b0, trig_en = 1'b0;
  logic [STEP_W-1:0] f_start = '0, f_stop = '0, delta = '0;
  logic              lg = 1'b0;
  logic [5:0]        shift = '0;
  logic [1:0]        mode = '0;
  logic [31:0]       dwell = '0;
  logic [STEP_W-1:0] step_o;
  logic              step_upd_o, busy_o, done_o;
  logic [15:0]       pass_cnt_o;

  int n_chk = 0, n_err = 0;
  logic [63:0] exp_q[$];

  asg_sweep_ctrl #(.RSZ(14), .STEP_W(STEP_W), .TICK_DIV(4)) dut (
    .dac_clk_i(clk), .dac_rstn_i(rst_n), .cfg_en_i(en), .cfg_start_i(start),
    .cfg_stop_i(stop), .trig_i(trig), .cfg_trig_en_i(trig_en),
    .cfg_f_start_i(f_start), .cfg_f_stop_i(f_stop), .cfg_delta_i(delta),
    .cfg_log_i(lg), .cfg_shift_i(shift), .cfg_mode_i(mode), .cfg_dwell_i(dwell),
    .step_o(step_o), .step_upd_o(step_upd_o), .busy_o(busy_o), .done_o(done_o),
    .pass_cnt_o(pass_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_sweep(input logic [63:0] fs, input logic [63:0] fe,
                             input logic [63:0] dl, input logic l, input int sh,
                             input int md, input int dw);
    @(negedge clk);
    f_start = STEP_W'(fs); f_stop = STEP_W'(fe); delta = STEP_W'(dl);
    lg = l; shift = 6'(sh); mode = 2'(md); dwell = 32'(dw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walks step_upd_o pulses, checking each new step (and spacing if hold>0).
  task automatic expect_seq(input string tag, input int hold);
    int cyc;
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc = 0;
      while (!step_upd_o && cyc < BUDGET) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("%s_to%0d", tag, i), 64'(cyc < BUDGET), 64'd1);
      if (i > 0 && hold > 0) chk($sformatf("%s_gap%0d", tag, i), 64'(cyc + 1), 64'(hold));
      chk($sformatf("%s_step%0d", tag, i), 64'(step_o), exp_q[i]);
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done_o && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int npulse;
    // reset state
    #12;
    chk("rst_step", 64'(step_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_pass", 64'(pass_cnt_o), 64'd0);
    chk("rst_upd",  64'(step_upd_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    f_start = STEP_W'(42);
    @(negedge clk);
    chk("idle_follow", 64'(step_o), 64'd42);

    // linear one-shot, config changes after start must be ignored
    start_sweep(100, 130, 10, 0, 0, 0, 2);
    chk("lin_busy", 64'(busy_o), 64'd1);
    f_stop = STEP_W'(999); delta = STEP_W'(1);
    exp_q = '{64'd100, 64'd110, 64'd120, 64'd130};
    expect_seq("lin", 8);
    wait_done("lin");
    chk("lin_pass", 64'(pass_cnt_o), 64'd1);
    chk("lin_final", 64'(step_o), 64'd130);

    // clamp on the way up, then down sweep
    start_sweep(100, 125, 10, 0, 0, 0, 1);
    chk("clamp_done_clr", 64'(done_o), 64'd0);
    exp_q = '{64'd100, 64'd110, 64'd120, 64'd125};
    expect_seq("clamp", 4);
    wait_done("clamp");
    chk("clamp_final", 64'(step_o), 64'd125);
    start_sweep(125, 100, 10, 0, 0, 3, 0);
    exp_q = '{64'd125, 64'd115, 64'd105, 64'd100};
    expect_seq("down", 4);
    wait_done("down");
    chk("down_pass", 64'(pass_cnt_o), 64'd1);

    // geometric
    start_sweep(1024, 2000, 0, 1, 2, 0, 1);
    exp_q = '{64'd1024, 64'd1280, 64'd1600, 64'd2000};
    expect_seq("geo", 4);
    wait_done("geo");
    start_sweep(2, 100, 0, 1, 4, 0, 1);
    exp_q = '{64'd2, 64'd3, 64'd4, 64'd5};
    expect_seq("geo_min", 4);

    // ping-pong (restarts the running sweep), then abort
    start_sweep(100, 120, 10, 0, 0, 2, 1);
    exp_q = '{64'd100, 64'd110, 64'd120, 64'd110, 64'd100, 64'd110};
    expect_seq("pp", 0);
    chk("pp_pass", 64'(pass_cnt_o), 64'd2);
    chk("pp_busy", 64'(busy_o), 64'd1);
    stop = 1'b1; f_start = STEP_W'(77);
    @(negedge clk);
    stop = 1'b0;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_pass", 64'(pass_cnt_o), 64'd2);
    chk("abort_step", 64'(step_o), 64'd77);

    // start and stop together while busy: stop wins
    start_sweep(100, 200, 10, 0, 0, 0, 1);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 64'(busy_o), 64'd0);
    trig = 1'b1; trig_en = 1'b0;
    @(negedge clk);
    trig = 1'b0;
    chk("trig_off_busy", 64'(busy_o), 64'd0);
    f_start = STEP_W'(300); f_stop = STEP_W'(400); trig = 1'b1; trig_en = 1'b1;
    @(negedge clk);
    trig = 1'b0; trig_en = 1'b0;
    chk("trig_on_busy", 64'(busy_o), 64'd1);
    chk("trig_on_step", 64'(step_o), 64'd300);
    repeat (3) @(negedge clk);
    start_sweep(50, 60, 5, 0, 0, 0, 1);
    chk("restart_step", 64'(step_o), 64'd50);

    // zero delta, distinct endpoints: holds at start, stays busy
    start_sweep(100, 200, 0, 0, 0, 0, 1);
    npulse = 0;
    @(negedge clk);
    repeat (40) begin
      if (step_upd_o) npulse++;
      @(negedge clk);
    end
    chk("d0_pulses", 64'(npulse), 64'd0);
    chk("d0_step", 64'(step_o), 64'd100);
    chk("d0_busy", 64'(busy_o), 64'd1);

    // repeat mode, then async reset mid-dwell
    start_sweep(100, 120, 10, 0, 0, 1, 1);
    exp_q = '{64'd100, 64'd110, 64'd120, 64'd100, 64'd110};
    expect_seq("rep", 4);
    chk("rep_pass", 64'(pass_cnt_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_step", 64'(step_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_pass", 64'(pass_cnt_o), 64'd0);
    chk("arst_upd",  64'(step_upd_o), 64'd0);
    chk("arst_done", 64'(done_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    f_start = STEP_W'(555);
    @(negedge clk);
    chk("post_rst_step", 64'(step_o), 64'd555);
    chk("post_rst_busy", 64'(busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
